// File: rtl/cmp_arbiter.sv
// Round-robin arbiter sharing one magnitude comparator among NREQ requesters.
// Define CMP_ARB_SIGNED_EN to compare operands as two's-complement; default is unsigned.
`timescale 1ns/1ps

module cmp_arbiter #(
  parameter int N    = 32,
  parameter int NREQ = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*N-1:0] req_a,
  input  logic [NREQ*N-1:0] req_b,
  output logic [NREQ-1:0]   rsp_valid,
  input  logic [NREQ-1:0]   rsp_ready,
  output logic              rsp_agb,
  output logic              rsp_alb,
  output logic              rsp_aeb
);

  // state  | meaning
  // IDLE   | arbitrate; accept the round-robin winner
  // CMP    | compare latched operands, register flags
  // RESP   | present flags to owner until it accepts
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CMP  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_t         state_q, state_d;
  logic [PW-1:0]  ptr_q, ptr_d;
  logic [PW-1:0]  owner_q, owner_d;
  logic [N-1:0]   op_a_q, op_a_d;
  logic [N-1:0]   op_b_q, op_b_d;
  logic           agb_q, agb_d;
  logic           alb_q, alb_d;
  logic           aeb_q, aeb_d;

  logic           found;
  logic [PW-1:0]  win;
  logic [PW-1:0]  idx;
  logic           cmp_gt, cmp_lt, cmp_eq;

  // Search starts just past the last winner, so it ends up lowest priority.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = PW'((int'(ptr_q) + k) % NREQ);
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  always_comb begin
    cmp_eq = (op_a_q == op_b_q);
`ifdef CMP_ARB_SIGNED_EN
    cmp_gt = ($signed(op_a_q) > $signed(op_b_q));
    cmp_lt = ($signed(op_a_q) < $signed(op_b_q));
`else
    cmp_gt = (op_a_q > op_b_q);
    cmp_lt = (op_a_q < op_b_q);
`endif
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    owner_d   = owner_q;
    op_a_d    = op_a_q;
    op_b_d    = op_b_q;
    agb_d     = agb_q;
    alb_d     = alb_q;
    aeb_d     = aeb_q;
    req_ready = '0;
    rsp_valid = '0;
    unique case (state_q)
      S_IDLE: begin
        if (found) begin
          req_ready[win] = 1'b1;
          op_a_d         = req_a[int'(win)*N +: N];
          op_b_d         = req_b[int'(win)*N +: N];
          ptr_d          = win;
          owner_d        = win;
          state_d        = S_CMP;
        end
      end
      S_CMP: begin
        agb_d   = cmp_gt;
        alb_d   = cmp_lt;
        aeb_d   = cmp_eq;
        state_d = S_RESP;
      end
      S_RESP: begin
        rsp_valid[owner_q] = 1'b1;
        if (rsp_ready[owner_q]) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      ptr_q   <= PW'(NREQ - 1);
      owner_q <= '0;
      op_a_q  <= '0;
      op_b_q  <= '0;
      agb_q   <= 1'b0;
      alb_q   <= 1'b0;
      aeb_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      agb_q   <= agb_d;
      alb_q   <= alb_d;
      aeb_q   <= aeb_d;
    end
  end

  assign rsp_agb = agb_q;
  assign rsp_alb = alb_q;
  assign rsp_aeb = aeb_q;

endmodule

// File: tb/tb_cmp_arbiter.sv
// Scoreboard bench for cmp_arbiter: directed requests push expected responses,
// a monitor pops and compares on every response handshake.
`timescale 1ns/1ps

module tb_cmp_arbiter;
  localparam int N    = 32;
  localparam int NREQ = 4;
  localparam logic [2:0] GT = 3'b100;
  localparam logic [2:0] LT = 3'b010;
  localparam logic [2:0] EQ = 3'b001;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid, req_ready, rsp_valid, rsp_ready;
  logic [NREQ*N-1:0] req_a, req_b;
  logic              rsp_agb, rsp_alb, rsp_aeb;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int         id;
    logic [2:0] fl;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  cmp_arbiter #(.N(N), .NREQ(NREQ)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_agb   (rsp_agb),
    .rsp_alb   (rsp_alb),
    .rsp_aeb   (rsp_aeb)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [N-1:0] a, input logic [N-1:0] b);
    req_a[i*N +: N] = a;
    req_b[i*N +: N] = b;
  endtask

  task automatic expect_rsp(input int id, input logic [2:0] fl);
    exp_t e;
    e.id = id;
    e.fl = fl;
    exp_q.push_back(e);
  endtask

  // Monitor: every response handshake must match the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && ((rsp_valid & rsp_ready) != '0)) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_rsp: rsp_valid=%b with nothing expected", rsp_valid);
      end else begin
        e = exp_q.pop_front();
        chk("rsp_owner", rsp_valid, 64'(1) << e.id);
        chk("rsp_flags", {rsp_agb, rsp_alb, rsp_aeb}, e.fl);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    rsp_ready = '0;
    req_a     = '0;
    req_b     = '0;
    tick(2);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_req_ready", req_ready, 0);
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_flags", {rsp_agb, rsp_alb, rsp_aeb}, 0);
    tick(1);

    // single request, a=5 b=3
    rsp_ready = 4'b1111;
    set_op(0, 32'd5, 32'd3);
    req_valid = 4'b0001;
    expect_rsp(0, GT);
    @(negedge clk);
    chk("t1_grant", req_ready, 4'b0001);
    tick(1);
    req_valid = '0;
    @(negedge clk);
    chk("t1_cmp_no_rsp", rsp_valid, 0);
    chk("t1_cmp_no_grant", req_ready, 0);
    tick(1);
    @(negedge clk);
    chk("t1_rsp_valid", rsp_valid, 4'b0001);
    tick(1);
    @(negedge clk);
    chk("t1_back_idle", rsp_valid, 0);

    // strict rotation from reset with all requesters held
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    for (int i = 0; i < NREQ; i++) set_op(i, 32'd7, 32'd7);
    req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) expect_rsp(k % 4, EQ);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("t2_grant", req_ready, 64'(1) << (k % 4));
      tick(1);
      if (k == 4) req_valid = '0;
      @(negedge clk);
      chk("t2_busy_cmp", req_ready, 0);
      tick(1);
      @(negedge clk);
      chk("t2_busy_rsp", req_ready, 0);
      tick(1);
    end

    // stalled response for requester 2; requester 0 waits meanwhile
    set_op(2, 32'd1, 32'd9);
    set_op(0, 32'd4, 32'd4);
    rsp_ready = 4'b1011;
    req_valid = 4'b0101;
    expect_rsp(2, LT);
    expect_rsp(0, EQ);
    @(negedge clk);
    chk("t3_grant2", req_ready, 4'b0100);
    tick(1);
    req_valid = 4'b0001;
    tick(1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t3_hold_valid", rsp_valid, 4'b0100);
      chk("t3_hold_flags", {rsp_agb, rsp_alb, rsp_aeb}, LT);
      chk("t3_no_grant", req_ready, 0);
      tick(1);
    end
    rsp_ready = 4'b1111;
    @(negedge clk);
    tick(1);
    @(negedge clk);
    chk("t3_grant0", req_ready, 4'b0001);
    tick(1);
    req_valid = '0;
    tick(2);

    // all-ones versus one
    set_op(3, 32'hFFFF_FFFF, 32'd1);
    req_valid = 4'b1000;
`ifdef CMP_ARB_SIGNED_EN
    expect_rsp(3, LT);
`else
    expect_rsp(3, GT);
`endif
    @(negedge clk);
    chk("t4_grant3", req_ready, 4'b1000);
    tick(1);
    req_valid = '0;
    tick(2);

    // reset during CMP aborts requester 1
    set_op(1, 32'd100, 32'd50);
    req_valid = 4'b0010;
    @(negedge clk);
    chk("t5_grant1", req_ready, 4'b0010);
    tick(1);
    req_valid = '0;
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    @(negedge clk);
    chk("t5_flags_reset", {rsp_agb, rsp_alb, rsp_aeb}, 0);
    chk("t5_no_rsp", rsp_valid, 0);
    tick(1);
    @(negedge clk);
    chk("t5_still_no_rsp", rsp_valid, 0);
    tick(1);
    set_op(0, 32'd10, 32'd20);
    req_valid = 4'b0011;
    expect_rsp(0, LT);
    expect_rsp(1, GT);
    @(negedge clk);
    chk("t5_grant0_first", req_ready, 4'b0001);
    tick(1);
    req_valid = 4'b0010;
    tick(2);
    @(negedge clk);
    chk("t5_grant1_next", req_ready, 4'b0010);
    tick(1);
    req_valid = '0;
    tick(2);

    // requests on 1 and 3 arrive while requester 0 is in RESP
    set_op(0, 32'd3, 32'd3);
    rsp_ready = 4'b1110;
    req_valid = 4'b0001;
    expect_rsp(0, EQ);
    expect_rsp(1, EQ);
`ifdef CMP_ARB_SIGNED_EN
    expect_rsp(3, GT);
`else
    expect_rsp(3, LT);
`endif
    @(negedge clk);
    chk("t6_grant0", req_ready, 4'b0001);
    tick(1);
    req_valid = '0;
    tick(1);
    set_op(1, 32'd2, 32'd2);
    set_op(3, 32'd0, 32'hFFFF_FFFF);
    req_valid = 4'b1010;
    @(negedge clk);
    chk("t6_no_grant_in_resp", req_ready, 0);
    chk("t6_rsp0_valid", rsp_valid, 4'b0001);
    tick(1);
    rsp_ready = 4'b1111;
    @(negedge clk);
    tick(1);
    @(negedge clk);
    chk("t6_grant1", req_ready, 4'b0010);
    tick(1);
    req_valid = 4'b1000;
    tick(2);
    @(negedge clk);
    chk("t6_grant3", req_ready, 4'b1000);
    tick(1);
    req_valid = '0;
    tick(3);

    chk("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
